// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: N-slot page-decoded interconnect for the FemtoRV32 bus with slot latch,
// busy watchdog, unmapped-access policy and sticky error capture. Optional macro: FEMTO_BUS_PERF_EN.

module femto_bus_slot #(
  parameter logic [15:0] PAGE = 16'h0000
) (
  input  logic [15:0] page,
  output logic        hit
);
  assign hit = (page == PAGE);
endmodule

module femto_bus_fabric #(
  parameter int                      N_SLOTS        = 4,
  parameter logic [N_SLOTS*16-1:0]   SLOT_PAGES     = {16'h0001, 16'h0041, 16'h0040, 16'h0000},
  parameter int                      DEFAULT_SLOT   = 0,
  parameter bit                      UNMAPPED_ERR   = 1'b0,
  parameter int                      TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wmask,
  input  logic                  mem_rstrb,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rbusy,
  output logic                  mem_wbusy,
  output logic [N_SLOTS-1:0]    s_sel,
  output logic [N_SLOTS-1:0]    s_rd,
  output logic [N_SLOTS-1:0]    s_wr,
  input  logic [N_SLOTS*32-1:0] s_rdata,
  input  logic [N_SLOTS-1:0]    s_rbusy,
  input  logic [N_SLOTS-1:0]    s_wbusy,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic [1:0]            err_cause,
  output logic [31:0]           err_addr
`ifdef FEMTO_BUS_PERF_EN
  ,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [15:0]           perf_to_cnt
`endif
);

  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  typedef struct packed {
    logic        flag;
    logic [1:0]  cause;
    logic [31:0] addr;
  } err_t;

  state_t                    state, state_n;
  logic [IW-1:0]             cur_slot, dec_idx, idx;
  logic                      cur_rd;
  logic [31:0]               tx_addr;
  logic [CW-1:0]             cnt, cnt_n;
  logic                      unm_rd_q;
  logic [N_SLOTS-1:0]        hit;
  logic [N_SLOTS-1:0][31:0]  rdata_a;
  logic                      dec_hit, dec_valid, wr_req, rd_req, strobe, in_idle;
  logic                      unm_ev, unm_rd, to_ev, busy_cur;
  err_t                      err_q;
  logic                      unused_wdata;

  // Slaves take write data straight off the CPU bus; the fabric never looks at it.
  assign unused_wdata = ^mem_wdata;

  genvar g;
  generate
    for (g = 0; g < N_SLOTS; g++) begin : g_slot
      femto_bus_slot #(.PAGE(SLOT_PAGES[g*16 +: 16])) u_slot (
        .page (mem_addr[31:16]),
        .hit  (hit[g])
      );
    end
  endgenerate

  // Scan high to low so the lowest matching slot wins.
  always_comb begin
    dec_idx = IW'(DEFAULT_SLOT);
    dec_hit = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_idx = IW'(i);
        dec_hit = 1'b1;
      end
    end
  end

  assign dec_valid = dec_hit | !UNMAPPED_ERR;
  assign wr_req    = |mem_wmask;
  assign rd_req    = mem_rstrb & ~wr_req;
  assign strobe    = mem_rstrb | wr_req;
  assign in_idle   = (state == S_IDLE);

  assign s_sel = dec_valid ? (N_SLOTS'(1) << dec_idx) : '0;
  assign s_rd  = s_sel & {N_SLOTS{rd_req}};
  assign s_wr  = s_sel & {N_SLOTS{wr_req}};

  assign rdata_a  = s_rdata;
  assign idx      = in_idle ? dec_idx : cur_slot;
  assign busy_cur = (state == S_WR) ? s_wbusy[cur_slot] : s_rbusy[cur_slot];
  assign unm_ev   = in_idle & strobe & ~dec_valid;
  assign unm_rd   = in_idle & rd_req & ~dec_valid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    to_ev   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (strobe && dec_valid) state_n = wr_req ? S_WR : S_RD;
      end
      S_RD, S_WR: begin
        if (!busy_cur) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_n = S_DONE;
          to_ev   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    case (state)
      S_IDLE: begin
        mem_rbusy = dec_valid & s_rbusy[idx];
        mem_wbusy = dec_valid & s_wbusy[idx];
      end
      S_RD:    mem_rbusy = s_rbusy[idx];
      S_WR:    mem_wbusy = s_wbusy[idx];
      default: ;
    endcase
    mem_rdata = rdata_a[idx];
    // Error data covers a timed-out read and both cycles the CPU may sample an unmapped read.
    if ((state == S_DONE && cur_rd) || unm_rd || unm_rd_q) mem_rdata = ERR_DATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cur_slot <= '0;
      cur_rd   <= 1'b0;
      tx_addr  <= '0;
      cnt      <= '0;
      unm_rd_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      unm_rd_q <= unm_rd;
      if (in_idle && strobe && dec_valid) begin
        cur_slot <= dec_idx;
        cur_rd   <= ~wr_req;
        tx_addr  <= mem_addr;
      end
    end
  end

  // A new error outranks a coincident clear so nothing is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= '0;
    end else if (to_ev || unm_ev) begin
      if (!err_q.flag || err_clr) begin
        err_q.flag  <= 1'b1;
        err_q.cause <= {unm_ev, to_ev};
        err_q.addr  <= to_ev ? tx_addr : mem_addr;
      end else begin
        err_q.cause <= err_q.cause | {unm_ev, to_ev};
      end
    end else if (err_clr) begin
      err_q <= '0;
    end
  end

  assign err_flag  = err_q.flag;
  assign err_cause = err_q.cause;
  assign err_addr  = err_q.addr;

`ifdef FEMTO_BUS_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
      perf_to_cnt <= '0;
    end else if (err_clr) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
      perf_to_cnt <= '0;
    end else begin
      if (|s_rd) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (|s_wr) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (to_ev) perf_to_cnt <= perf_to_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Directed bench for femto_bus_fabric: unmapped-error build with an 8-cycle watchdog,
// read data checked through an expected-data queue. Honours FEMTO_BUS_PERF_EN.

module tb_femto_bus_fabric;
  localparam int          N     = 4;
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            resetn;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata, err_addr;
  logic [3:0]      mem_wmask;
  logic            mem_rstrb, mem_rbusy, mem_wbusy, err_clr, err_flag;
  logic [1:0]      err_cause;
  logic [N-1:0]    s_sel, s_rd, s_wr, s_rbusy, s_wbusy;
  logic [N*32-1:0] s_rdata;
`ifdef FEMTO_BUS_PERF_EN
  logic [31:0]     perf_rd_cnt, perf_wr_cnt;
  logic [15:0]     perf_to_cnt;
`endif

  int n_pass = 0, n_chk = 0, n_fail = 0;
  int m_rd = 0, m_wr = 0, m_to = 0;
  logic [31:0] exp_q[$];

  femto_bus_fabric #(
    .N_SLOTS        (N),
    .UNMAPPED_ERR   (1'b1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .mem_wbusy (mem_wbusy),
    .s_sel     (s_sel),
    .s_rd      (s_rd),
    .s_wr      (s_wr),
    .s_rdata   (s_rdata),
    .s_rbusy   (s_rbusy),
    .s_wbusy   (s_wbusy),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_cause (err_cause),
    .err_addr  (err_addr)
`ifdef FEMTO_BUS_PERF_EN
    ,
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt),
    .perf_to_cnt (perf_to_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_err(input string tag, input logic f, input logic [1:0] c, input logic [31:0] a);
    smp();
    chk({tag, ".err_flag"}, 32'(err_flag), 32'(f));
    chk({tag, ".err_cause"}, 32'(err_cause), 32'(c));
    chk({tag, ".err_addr"}, err_addr, a);
    cyc();
  endtask

  task automatic chk_perf(input string tag);
`ifdef FEMTO_BUS_PERF_EN
    chk({tag, ".perf_rd"}, perf_rd_cnt, 32'(m_rd));
    chk({tag, ".perf_wr"}, perf_wr_cnt, 32'(m_wr));
    chk({tag, ".perf_to"}, 32'(perf_to_cnt), 32'(m_to));
`endif
  endtask

  task automatic clr();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    m_rd = 0; m_wr = 0; m_to = 0;
  endtask

  // One bus transaction; the modelled slave raises busy the cycle after the strobe for nbusy cycles.
  task automatic txn(input string tag, input bit wr, input bit rd,
                     input logic [31:0] addr, input logic [31:0] addr2, input int slot,
                     input int nbusy, input logic [31:0] sdata, input logic [N-1:0] exp_sel,
                     input int exp_hi, input logic [31:0] exp_data, input bit exp_to);
    int hi;
    bit done;
    hi = 0;
    done = 1'b0;
    mem_addr  = addr;
    mem_rstrb = rd;
    mem_wmask = wr ? 4'hF : 4'h0;
    mem_wdata = addr ^ 32'h5A5A_5A5A;
    s_rdata[slot*32 +: 32] = sdata;
    if (rd && !wr) exp_q.push_back(exp_data);
    smp();
    chk({tag, ".s_sel"}, 32'(s_sel), 32'(exp_sel));
    chk({tag, ".s_wr"}, 32'(s_wr), wr ? 32'(exp_sel) : 32'd0);
    chk({tag, ".s_rd"}, 32'(s_rd), (rd && !wr) ? 32'(exp_sel) : 32'd0);
    if (rd && !wr && exp_sel == '0) chk({tag, ".unm_rdata0"}, mem_rdata, ERR_D);
    if (exp_sel != '0) begin
      if (wr) m_wr++;
      else if (rd) m_rd++;
    end
    if (exp_to) m_to++;
    cyc();
    mem_rstrb = 1'b0;
    mem_wmask = 4'h0;
    mem_addr  = addr2;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (wr) s_wbusy[slot] = (c <= nbusy);
      else    s_rbusy[slot] = (c <= nbusy);
      smp();
      if ((wr ? mem_wbusy : mem_rbusy) === 1'b1) hi++;
      else begin
        done = 1'b1;
        if (rd && !wr) chk({tag, ".rdata"}, mem_rdata, exp_q.pop_front());
        if (wr) s_wbusy[slot] = 1'b0;
        else    s_rbusy[slot] = 1'b0;
      end
      cyc();
    end
    chk({tag, ".busy_cycles"}, 32'(hi), 32'(exp_hi));
  endtask

  initial begin
    resetn    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    err_clr   = 1'b0;
    s_rdata   = '0;
    s_rbusy   = '0;
    s_wbusy   = '0;
    #1;
    chk("rst.err_flag", 32'(err_flag), 32'd0);
    chk("rst.err_cause", 32'(err_cause), 32'd0);
    chk("rst.err_addr", err_addr, 32'd0);
    chk("rst.s_sel", 32'(s_sel), 32'b0001);
    chk("rst.mem_rbusy", 32'(mem_rbusy), 32'd0);
    chk_perf("rst");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc();

    txn("rd1", 1'b0, 1'b1, 32'h0040_0004, 32'h0040_0004, 1, 3, 32'h55, 4'b0010, 3, 32'h55, 1'b0);
    chk_err("rd1", 1'b0, 2'b00, 32'h0);

    // Address moves to slot 0 (idle, different data) while slot 1 is still busy.
    s_rdata[31:0] = 32'h0000_0BAD;
    txn("route", 1'b0, 1'b1, 32'h0040_0000, 32'h0000_0000, 1, 4, 32'hA1, 4'b0010, 4, 32'hA1, 1'b0);

    txn("wr_rd", 1'b1, 1'b1, 32'h0041_0000, 32'h0041_0000, 2, 2, 32'h0, 4'b0100, 2, 32'h0, 1'b0);
    txn("rd0w", 1'b0, 1'b1, 32'h0001_0008, 32'h0001_0008, 3, 0, 32'h77, 4'b1000, 0, 32'h77, 1'b0);

    txn("unm_wr", 1'b1, 1'b0, 32'h1234_0000, 32'h1234_0000, 0, 0, 32'h0BAD, 4'b0000, 0, 32'h0, 1'b0);
    chk_err("unm_wr", 1'b1, 2'b10, 32'h1234_0000);

    txn("to1", 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 0, 100, 32'h1111_1111, 4'b0001, 8, ERR_D, 1'b1);
    chk_err("to1", 1'b1, 2'b11, 32'h1234_0000);

    chk_perf("pre_clr");
    clr();
    chk_err("clr", 1'b0, 2'b00, 32'h0);
    chk_perf("post_clr");

    txn("to2", 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 0, 100, 32'h2222_2222, 4'b0001, 8, ERR_D, 1'b1);
    chk_err("to2", 1'b1, 2'b01, 32'h0000_0010);

    txn("unm_rd", 1'b0, 1'b1, 32'h2000_0000, 32'h2000_0000, 0, 0, 32'h0BAD, 4'b0000, 0, ERR_D, 1'b0);
    chk_err("unm_rd", 1'b1, 2'b11, 32'h0000_0010);

    // Clear pulse in the same cycle as a fresh unmapped read: the new error is kept.
    mem_addr  = 32'h3000_0000;
    mem_rstrb = 1'b1;
    err_clr   = 1'b1;
    smp();
    chk("clrhit.rdata", mem_rdata, ERR_D);
    chk("clrhit.s_rd", 32'(s_rd), 32'd0);
    cyc();
    mem_rstrb = 1'b0;
    err_clr   = 1'b0;
    m_rd = 0; m_wr = 0; m_to = 0;
    chk_err("clrhit", 1'b1, 2'b10, 32'h3000_0000);
    chk_perf("clrhit");

    // Asynchronous reset in the middle of a read; slot 1 stays busy afterwards.
    mem_addr  = 32'h0040_0000;
    mem_rstrb = 1'b1;
    cyc();
    mem_rstrb  = 1'b0;
    s_rbusy[1] = 1'b1;
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    chk("arst.err_flag", 32'(err_flag), 32'd0);
    chk("arst.err_cause", 32'(err_cause), 32'd0);
    chk("arst.err_addr", err_addr, 32'd0);
    m_rd = 0; m_wr = 0; m_to = 0;
    chk_perf("arst");
    cyc();
    resetn = 1'b1;
    cyc();
    txn("fresh", 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 3, 0, 32'h3C3C_3C3C, 4'b1000, 0, 32'h3C3C_3C3C, 1'b0);
    s_rbusy[1] = 1'b0;
    chk_perf("fresh");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/femto_bus_fabric.md
Name: femto_bus_fabric

Overview:
- Parametrised N-slot memory-mapped interconnect between the FemtoRV32 bus and its peripherals; successor to the fixed 7-way one-hot chip-select/read-mux of the femto SoC top.
- Decodes mem_addr[31:16] against a per-slot page table and routes strobes, read data and busy back to the CPU.
- Adds a per-transaction slot latch, a busy-timeout watchdog, an unmapped-access policy and a sticky error capture register.

Parameters:
- N_SLOTS, 4, number of peripheral slots (1..16).
- SLOT_PAGES, {16'h0001,16'h0041,16'h0040,16'h0000}, N_SLOTS*16-bit page table; slot i page = SLOT_PAGES[i*16+:16].
- DEFAULT_SLOT, 0, slot used for unmatched addresses when UNMAPPED_ERR=0.
- UNMAPPED_ERR, 0, 1 = unmatched access is an error and is not forwarded.
- TIMEOUT_CYCLES, 1024, busy cycles tolerated before forced completion (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or unmapped read.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU write data (passed through to slots unchanged)
- mem_wmask  in  4  CPU write byte mask; any bit set = write strobe
- mem_rstrb  in  1  CPU read strobe
- mem_rdata  out  32  read data to CPU
- mem_rbusy  out  1  read busy to CPU
- mem_wbusy  out  1  write busy to CPU
- s_sel  out  N_SLOTS  one-hot slot select (all-zero allowed)
- s_rd  out  N_SLOTS  per-slot read strobe
- s_wr  out  N_SLOTS  per-slot write strobe
- s_rdata  in  N_SLOTS*32  per-slot read data, slot i at [i*32+:32]
- s_rbusy  in  N_SLOTS  per-slot read busy
- s_wbusy  in  N_SLOTS  per-slot write busy
- err_clr  in  1  synchronous pulse; clears err_flag/err_addr/err_cause
- err_flag  out  1  sticky error indication
- err_cause  out  2  01 timeout, 10 unmapped, 11 both since last clear
- err_addr  out  32  address of first error since last clear

Behaviour:
- Decode (combinational): hit[i] = mem_addr[31:16]==page i; lowest index wins. No hit: DEFAULT_SLOT if UNMAPPED_ERR=0, else no slot (s_sel all zero).
- s_rd = s_sel & {N{mem_rstrb}}; s_wr = s_sel & {N{|mem_wmask}}. Write and read strobe in same cycle: write forwarded, read suppressed.
- FSM: IDLE, RD, WR, DONE.
  - IDLE: on strobe to a valid slot, latch cur_slot <= decoded index, go RD/WR.
  - RD/WR: stay while s_rbusy/s_wbusy[cur_slot]=1; when it drops, go IDLE.
  - Timeout: when busy has been high TIMEOUT_CYCLES cycles in RD/WR, go DONE.
  - DONE: lasts one cycle, then IDLE.
- Routing index = decoded index in IDLE, cur_slot otherwise; address changes after the strobe do not redirect data or busy.
- mem_rbusy = s_rbusy[idx] in IDLE/RD, 0 in DONE. mem_wbusy follows the same rule with s_wbusy.
- mem_rdata = s_rdata[idx], with two exceptions:
  - ERR_DATA during DONE after a read timeout.
  - ERR_DATA in the strobe cycle and following cycle of an unmapped read.
  - Latency is zero added cycles versus a direct connection.
- Busy counter: 0 in IDLE; saturates and clears on every IDLE entry.
- Unmapped access (UNMAPPED_ERR=1): no slot strobe, busy outputs 0, set err.
- Errors:
  - First error since clear captures err_addr = mem_addr of the strobe (latched at strobe for timeouts) and sets err_flag.
  - Later errors only OR into err_cause.
  - err_clr coincident with a new error: the new error wins (flag stays set, new addr captured).
- Reset (async, any state): state IDLE, cur_slot 0, counter 0, err_flag 0, err_cause 0, err_addr 0. Combinational outputs follow inputs.

Optional Feature:
- FEMTO_BUS_PERF_EN defined: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0], perf_to_cnt[15:0].
  - perf_rd_cnt/perf_wr_cnt increment once per forwarded read/write strobe; perf_to_cnt increments on each DONE entry.
  - All wrap modulo width, reset to 0 and clear on err_clr.
- Undefined: ports and logic absent.

Test Plan:
- Read 0x0040_0004, slot1 rbusy 3 cycles, rdata 0x55 -> s_rd=0b0010 for 1 cycle; mem_rbusy high 3 cycles; mem_rdata=0x55; err_flag=0.
- Strobe at 0x0040_0000 then change addr to 0x0000_0000 while busy -> routing stays slot1 until busy drops.
- TIMEOUT_CYCLES=8, slot0 rbusy stuck at 0x0000_0010 -> mem_rbusy falls after 8 cycles; mem_rdata=0xDEADBEEF for one cycle; err_cause=01; err_addr=0x10.
- UNMAPPED_ERR=1, write 0x1234_0000 -> s_wr=0, mem_wbusy=0, err_cause=10; a following timeout -> err_cause=11 with err_addr unchanged; err_clr -> all zero.
- Assert resetn low mid-RD -> all error outputs 0 immediately; next strobe decodes fresh.
- PERF_EN: 5 reads, 3 writes, 1 timeout -> counts 5/3/1; err_clr -> 0/0/0.
